// File: rtl/imem_loader.sv
// imem_loader: parses a framed byte stream and writes it into instruction memory.
// Holds the CPU while a frame is being loaded and flags range/checksum errors.
module imem_loader #(
  parameter int         MEM_DEPTH = 2048,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [10:0] mem_waddr,
  output logic [7:0]  mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_A0,
    S_A1,
    S_L0,
    S_L1,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [15:0] addr_q;
  logic [15:0] len_q;
  logic [7:0]  xsum_q;
  logic        acc;
  logic        is_sync;
  logic [15:0] len_full;
  logic [16:0] end_addr;
  logic        range_bad;
  logic        len_zero;
  logic        chk_ok;

  // Ready decode: DATA follows memory backpressure, DONE/ERR refuse input.
  always_comb begin
    in_ready = 1'b0;
    unique case (1'b1)
      (state == S_DATA): in_ready = mem_ready;
      (state == S_DONE),
      (state == S_ERR):  in_ready = 1'b0;
      default:           in_ready = 1'b1;
    endcase
    in_ready = in_ready & rst_n;
  end

  assign acc       = in_valid & in_ready;
  assign is_sync   = (in_data == SYNC_BYTE);
  assign len_full  = {in_data, len_q[7:0]};
  assign end_addr  = {1'b0, addr_q} + {1'b0, len_full};
  assign range_bad = (end_addr > 17'(MEM_DEPTH));
  assign len_zero  = (len_full == 16'd0);
  assign chk_ok    = (in_data == xsum_q);

  assign cpu_hold  = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic: one accepted byte advances each header field.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (acc && is_sync) state_n = S_A0;
      S_A0:   if (acc) state_n = S_A1;
      S_A1:   if (acc) state_n = S_L0;
      S_L0:   if (acc) state_n = S_L1;
      S_L1: begin
        if (acc) begin
          if (range_bad)     state_n = S_ERR;
          else if (len_zero) state_n = S_CHK;
          else               state_n = S_DATA;
        end
      end
      S_DATA: if (acc && len_q == 16'd1) state_n = S_CHK;
      S_CHK:  if (acc) state_n = chk_ok ? S_DONE : S_ERR;
      S_DONE: state_n = S_IDLE;
      S_ERR:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath: header capture, write pipeline register, running XOR, error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      len_q     <= '0;
      xsum_q    <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      mem_we <= 1'b0;
      if (acc) begin
        unique case (state)
          S_IDLE: begin
            if (is_sync) begin
              xsum_q   <= '0;
              err      <= 1'b0;
              err_code <= 2'b00;
            end
          end
          S_A0: addr_q[7:0]  <= in_data;
          S_A1: addr_q[15:8] <= in_data;
          S_L0: len_q[7:0]   <= in_data;
          S_L1: begin
            len_q[15:8] <= in_data;
            if (range_bad) begin
              err      <= 1'b1;
              err_code <= 2'b01;
            end
          end
          S_DATA: begin
            mem_we    <= 1'b1;
            mem_waddr <= addr_q[10:0];
            mem_wdata <= in_data;
            addr_q    <= addr_q + 16'd1;
            len_q     <= len_q - 16'd1;
            xsum_q    <= xsum_q ^ in_data;
          end
          S_CHK: begin
            if (!chk_ok) begin
              err      <= 1'b1;
              err_code <= 2'b10;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven, directed and random frames checked
// against a transaction-level model of the loader.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_ready = 1'b1;
  logic        mem_we;
  logic [10:0] mem_waddr;
  logic [7:0]  mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  imem_loader #(
    .MEM_DEPTH(2048),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mem_ready(mem_ready),
    .mem_we   (mem_we),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] a;
    logic [7:0]  d;
    int          t;
  } wr_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] n;
    bit          bad;
    int          code;
    int          nw;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   n_done = 0;
  int   n_err = 0;
  logic err_d = 1'b0;
  bit   mr_rand = 1'b0;
  bit   mr_val = 1'b1;
  bit   gaps = 1'b0;
  wr_t  got[$];
  vec_t tbl[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) got.push_back('{mem_waddr, mem_wdata, cyc});
    if (done) n_done++;
    if (err && !err_d) n_err++;
    err_d = err;
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      mem_ready = mr_rand ? ($urandom_range(0, 3) != 0) : mr_val;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: byte %0h not accepted in 200 cycles", b);
    end
  endtask

  task automatic run_frame(input string tag, input logic [15:0] a,
                           input logic [15:0] n, input bit bad,
                           input int ecode, input int enw);
    logic [7:0] d[$];
    logic [7:0] x;
    logic [7:0] b;
    bit         in_range;
    int         bad_wr;
    int         lim;
    x = 8'h00;
    bad_wr = 0;
    in_range = (int'(a) + int'(n) <= 2048);
    if (in_range) begin
      for (int i = 0; i < int'(n); i++) begin
        b = 8'($urandom);
        d.push_back(b);
        x ^= b;
      end
    end
    got.delete();
    n_done = 0;
    n_err = 0;
    send_byte(8'hA5);
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    if (!in_range) begin
      send_byte(8'h12);
      send_byte(8'h34);
    end else begin
      foreach (d[i]) send_byte(d[i]);
      send_byte(bad ? (x ^ 8'h5A) : x);
    end
    repeat (3) @(posedge clk);
    #1;
    lim = (got.size() < d.size()) ? got.size() : d.size();
    for (int i = 0; i < lim; i++) begin
      if (got[i].a !== 11'(a + 16'(i)) || got[i].d !== d[i]) bad_wr++;
    end
    chk({tag, "/nwrites"}, got.size(), enw);
    chk({tag, "/wcontent"}, bad_wr, 0);
    chk({tag, "/done"}, n_done, (ecode == 0) ? 1 : 0);
    chk({tag, "/errpulse"}, n_err, (ecode != 0) ? 1 : 0);
    chk({tag, "/code"}, err_code, ecode);
    chk({tag, "/errlvl"}, err, (ecode != 0) ? 1 : 0);
    chk({tag, "/hold"}, cpu_hold, 0);
  endtask

  initial begin
    logic [7:0]  rd[$];
    logic [15:0] ra;
    logic [15:0] rn;
    bit          rbad;
    int          rc;
    int          stall_bad;

    tbl.push_back('{16'h0070, 16'd2,     1'b0, 0, 2});
    tbl.push_back('{16'h07FE, 16'd2,     1'b0, 0, 2});
    tbl.push_back('{16'h07FF, 16'd2,     1'b0, 1, 0});
    tbl.push_back('{16'h0010, 16'd0,     1'b0, 0, 0});
    tbl.push_back('{16'h0000, 16'd1,     1'b1, 2, 1});
    tbl.push_back('{16'hFFFF, 16'd1,     1'b0, 1, 0});
    tbl.push_back('{16'h0800, 16'd0,     1'b0, 0, 0});
    tbl.push_back('{16'h0000, 16'h0801,  1'b0, 1, 0});
    tbl.push_back('{16'h0100, 16'hFFFF,  1'b0, 1, 0});
    tbl.push_back('{16'h0005, 16'd3,     1'b1, 2, 3});
    tbl.push_back('{16'h0000, 16'h0800,  1'b0, 0, 2048});

    #3;
    chk("reset_outs",
        {mem_we, mem_waddr, mem_wdata, cpu_hold, done, err, err_code, in_ready},
        0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reference frame: two back-to-back writes then done.
    got.delete();
    n_done = 0;
    n_err = 0;
    rd = '{8'hA5, 8'h70, 8'h00, 8'h02, 8'h00, 8'h30, 8'hF8, 8'hC8};
    foreach (rd[i]) send_byte(rd[i]);
    repeat (3) @(posedge clk);
    #1;
    chk("ref/nwrites", got.size(), 2);
    if (got.size() >= 2) begin
      chk("ref/w0", {got[0].a, got[0].d}, {11'd112, 8'h30});
      chk("ref/w1", {got[1].a, got[1].d}, {11'd113, 8'hF8});
      chk("ref/consecutive", got[1].t - got[0].t, 1);
    end
    chk("ref/done", n_done, 1);
    chk("ref/err", err, 0);
    chk("ref/hold", cpu_hold, 0);

    // Checksum error stays sticky until the next sync byte.
    got.delete();
    n_done = 0;
    n_err = 0;
    rd = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h10, 8'h11};
    foreach (rd[i]) send_byte(rd[i]);
    repeat (3) @(posedge clk);
    #1;
    chk("cse/nwrites", got.size(), 1);
    if (got.size() >= 1) chk("cse/w0", {got[0].a, got[0].d}, {11'd0, 8'h10});
    chk("cse/code", err_code, 2);
    chk("cse/errpulse", n_err, 1);
    repeat (5) @(posedge clk);
    #1;
    send_byte(8'h33);
    send_byte(8'h44);
    chk("cse/sticky", {err, err_code}, 3'b110);
    chk("cse/dropped", got.size(), 1);
    send_byte(8'hA5);
    chk("cse/cleared", {err, err_code, cpu_hold}, 4'b0001);
    rd = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    n_done = 0;
    foreach (rd[i]) send_byte(rd[i]);
    repeat (3) @(posedge clk);
    #1;
    chk("cse/next_done", n_done, 1);

    // Memory backpressure for three cycles in the middle of DATA.
    got.delete();
    n_done = 0;
    rd = '{8'hA5, 8'h20, 8'h00, 8'h04, 8'h00, 8'h01, 8'h02};
    foreach (rd[i]) send_byte(rd[i]);
    mr_val = 1'b0;
    in_data = 8'h03;
    in_valid = 1'b1;
    stall_bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (in_ready !== 1'b0) stall_bad++;
    end
    chk("stall/in_ready", stall_bad, 0);
    chk("stall/nwrites", got.size(), 2);
    @(posedge clk);
    #1;
    mr_val = 1'b1;
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04);
    repeat (3) @(posedge clk);
    #1;
    chk("stall/total", got.size(), 4);
    if (got.size() >= 4) begin
      chk("stall/w2", {got[2].a, got[2].d}, {11'h022, 8'h03});
      chk("stall/w3", {got[3].a, got[3].d}, {11'h023, 8'h04});
    end
    chk("stall/done", n_done, 1);

    // Reset in the middle of a frame.
    rd = '{8'hA5, 8'h40, 8'h00, 8'h04, 8'h00, 8'hAA, 8'hBB};
    foreach (rd[i]) send_byte(rd[i]);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst/outs",
        {mem_we, mem_waddr, mem_wdata, cpu_hold, done, err, err_code, in_ready},
        0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst/hold", cpu_hold, 0);
    run_frame("midrst/reload", 16'h0040, 16'd4, 1'b0, 0, 4);

    // Table of boundary frames.
    gaps = 1'b1;
    mr_rand = 1'b1;
    foreach (tbl[k]) begin
      run_frame($sformatf("tbl%0d", k), tbl[k].a, tbl[k].n, tbl[k].bad,
                tbl[k].code, tbl[k].nw);
    end

    // Random frames around the top of memory.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 0) ra = 16'($urandom_range(0, 2047));
      else ra = 16'($urandom_range(2036, 2060));
      if ($urandom_range(0, 9) == 0) ra = 16'($urandom);
      rn = 16'($urandom_range(0, 12));
      rbad = ($urandom_range(0, 3) == 0);
      if (int'(ra) + int'(rn) > 2048) rc = 1;
      else if (rbad) rc = 2;
      else rc = 0;
      run_frame($sformatf("rnd%0d", k), ra, rn, rbad, rc,
                (rc == 1) ? 0 : int'(rn));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 2048, number of byte locations in instruction memory.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-003 SHALL have port clk input 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n input 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_data input 8: incoming load-stream byte.
REQ-006 SHALL have port in_valid input 1: in_data is valid.
REQ-007 SHALL have port in_ready output 1: the loader accepts in_data this cycle.
REQ-008 SHALL have port mem_ready input 1: instruction memory can take a write this cycle.
REQ-009 SHALL have port mem_we output 1: byte write strobe to instruction memory.
REQ-010 SHALL have port mem_waddr output 11: byte write address.
REQ-011 SHALL have port mem_wdata output 8: byte write data.
REQ-012 SHALL have port cpu_hold output 1: holds the pipeline (f_pc frozen) while a frame is in progress.
REQ-013 SHALL have port done output 1: one-cycle pulse on a good frame.
REQ-014 SHALL have port err output 1: sticky error flag.
REQ-015 SHALL have port err_code output 2: 01 range, 10 checksum, 00 none.

Function
REQ-016 SHALL accept a byte only on a cycle where in_valid and in_ready are both 1.
REQ-017 SHALL use the frame format: SYNC_BYTE, addr_lo, addr_hi, len_lo, len_hi, len data bytes, chk. chk is the XOR of all data bytes. Address and length are little-endian, 16 bits each.
REQ-018 SHALL implement states IDLE, A0, A1, L0, L1, DATA, CHK, DONE, ERR.
REQ-019 SHALL, in IDLE, silently drop any non-sync byte; an accepted SYNC_BYTE moves to A0, clears err/err_code, and asserts cpu_hold.
REQ-020 SHALL advance A0->A1->L0->L1 with one accepted byte each, capturing address and length.
REQ-021 SHALL, at the L1 accept, compute addr+len in 17 bits; if the result > MEM_DEPTH, go to ERR with err_code=01 and perform no writes.
REQ-022 SHALL go from L1 to CHK when len=0; otherwise go to DATA.
REQ-023 SHALL drive in_ready=mem_ready in DATA, 1 in IDLE/A0/A1/L0/L1/CHK, and 0 in DONE/ERR.
REQ-024 SHALL, for each DATA accept, register mem_we=1, mem_waddr=current address, and mem_wdata=byte in the next cycle. mem_we is 0 otherwise.
REQ-025 SHALL, on each DATA accept, increment the current address and decrement the remaining count; at remaining count 0, go to CHK.
REQ-026 SHALL, at the CHK accept, compare the byte with the running XOR: equal -> DONE; unequal -> ERR with err_code=10. Bytes already written are not rolled back.
REQ-027 SHALL occupy DONE and ERR for exactly one cycle each, then return to IDLE. done=1 only in DONE; err=1 from entry into ERR until the next SYNC_BYTE accept.
REQ-028 SHALL assert cpu_hold from the cycle after the sync accept through the DONE/ERR cycle, and deassert it on return to IDLE.
REQ-029 SHALL clear the running XOR at sync accept.
REQ-030 SHALL treat a SYNC_BYTE value received outside IDLE as ordinary data or header.
REQ-031 SHALL, when mem_ready=0 in DATA, stall with no accept and no write, and with state and counters held.

Reset
REQ-032 SHALL, while rst_n=0, immediately force state=IDLE and set mem_we, mem_waddr, mem_wdata, cpu_hold, done, err, err_code, in_ready, counters, and XOR to 0.
REQ-033 SHALL, on reset mid-frame, abandon the frame; memory bytes already written remain. After rst_n rises, the next byte is parsed from IDLE.

Verification
REQ-034 SHALL pass: frame A5 70 00 02 00 30 F8 C8 -> writes [112]=30 and [113]=F8 on consecutive cycles, then a done pulse, err=0, cpu_hold low after DONE.
REQ-035 SHALL pass: frame A5 FF 07 02 00 ... -> (0x7FF+2=2049 > 2048) ERR, err_code=01, no mem_we, following data bytes dropped in IDLE.
REQ-036 SHALL pass: frame A5 00 00 01 00 10 11 -> write [0]=10, then ERR with err_code=10 and err sticky until the next A5.
REQ-037 SHALL pass: len=0 frame A5 10 00 00 00 00 -> done pulse, no writes.
REQ-038 SHALL pass: mem_ready held 0 for 3 cycles mid-DATA -> in_ready=0, no writes, and the address resumes unchanged.
REQ-039 SHALL pass: rst_n pulsed low after the 2nd data byte of a 4-byte frame -> all outputs 0 at once, cpu_hold drops, and a following good frame loads correctly.
